forward_folded: RTL and testbench

Time-multiplexed successor to the fully parallel forward-propagation unit. It computes OUT_PIXS dot products, each of IN_PIXS fixed-point pixels against a per-output filter, then adds a bias. It uses only LANES multipliers, reused over ceil(IN_PIXS/LANES) cycles per output, and adds valid/ready handshakes, overflow saturation and optional ReLU. It sits between the line-buffer/window stage and the next layer wherever DSP count matters more than throughput.

---
 rtl/forward_folded_pkg.sv | 24 ++
 rtl/forward_folded_if.sv | 24 ++
 rtl/forward_saturate.sv | 25 ++
 rtl/forward_folded.sv | 147 ++++++++++++++
 tb/tb_forward_folded.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/forward_folded_pkg.sv
// Shared types and width helpers for the folded forward-propagation unit.
package forward_folded_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    // Counter width that stays at least one bit for single-entry ranges.
    function automatic int cnt_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/forward_folded_if.sv
// Input-vector and result handshakes of forward_folded.
// A transfer happens on a rising clock edge where valid and ready are both high;
// the source holds its data stable while valid is high and ready is low.
interface forward_folded_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 24
);
    logic [0:IN_W-1]  in_pixels;
    logic             in_valid;
    logic             in_ready;
    logic [0:OUT_W-1] out_pixels;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_pixels, in_valid, out_ready,
        input  in_ready, out_pixels, out_valid
    );

    modport slave (
        input  in_pixels, in_valid, out_ready,
        output in_ready, out_pixels, out_valid
    );
endinterface

// File: rtl/forward_saturate.sv
// Signed clamp of an IN_W-bit value into the OUT_W-bit range, with optional ReLU.
module forward_saturate #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 12,
    parameter int RELU  = 0
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);
    localparam logic signed [IN_W-1:0] HI = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] LO = ~HI;

    logic signed [OUT_W-1:0] clamped;

    always_comb begin
        if (din > HI) begin
            clamped = HI[OUT_W-1:0];
        end else if (din < LO) begin
            clamped = LO[OUT_W-1:0];
        end else begin
            clamped = din[OUT_W-1:0];
        end
        dout = (RELU != 0 && clamped[OUT_W-1]) ? '0 : clamped;
    end
endmodule

// File: rtl/forward_folded.sv
// Folded dot-product layer: LANES multipliers swept over CHUNKS cycles per output,
// bias added on the first chunk, saturating (and optionally rectified) results.
module forward_folded
    import forward_folded_pkg::*;
#(
    parameter int IN_PIXS   = 4,
    parameter int OUT_PIXS  = 2,
    parameter int INT_BITW  = 4,
    parameter int FRAC_BITW = 4,
    parameter int LANES     = 1,
    parameter int RELU      = 0,
    parameter logic [0:(INT_BITW+FRAC_BITW)*IN_PIXS*OUT_PIXS-1] FLT = '0,
    parameter logic [0:(INT_BITW+2*FRAC_BITW)*OUT_PIXS-1]       BIAS = '0
) (
    input  logic           clock,
    input  logic           n_rst,
    forward_folded_if.slave bus,
    output state_t         dbg_state
);
    localparam int IN_BITW  = INT_BITW + FRAC_BITW;
    localparam int OUT_BITW = INT_BITW + 2 * FRAC_BITW;
    localparam int CHUNKS   = (IN_PIXS + LANES - 1) / LANES;
    localparam int ACC_BITW = 2 * IN_BITW + clog2(IN_PIXS) + 1;
    localparam int PROD_W   = 2 * IN_BITW;
    localparam int OP_W     = cnt_w(OUT_PIXS);
    localparam int K_W      = cnt_w(CHUNKS);

    state_t state, state_nxt;
    logic [OP_W-1:0] op;
    logic [K_W-1:0]  k;
    logic signed [ACC_BITW-1:0] acc, partial, base, sum;
    logic signed [OUT_BITW-1:0] bias_w, sat;
    logic [0:IN_BITW*IN_PIXS-1]   vec;
    logic [0:OUT_BITW*OUT_PIXS-1] out_reg;
    logic signed [PROD_W-1:0] prod [LANES];
    logic last_chunk, last_op;
    logic in_ready_d, out_valid_d;

    assign last_chunk = (k == K_W'(CHUNKS - 1));
    assign last_op    = (op == OP_W'(OUT_PIXS - 1));

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (last_chunk && last_op) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d  = (state == IDLE);
        out_valid_d = (state == DONE);
    end

    assign bus.in_ready   = in_ready_d;
    assign bus.out_valid  = out_valid_d;
    assign bus.out_pixels = out_reg;
    assign dbg_state      = state;

    // Each lane picks its pixel and filter word by constant index; lanes past IN_PIXS contribute zero.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic signed [PROD_W-1:0] pix_w, flt_w;
        int ip;
        always_comb begin
            pix_w = '0;
            flt_w = '0;
            ip    = 0;
            for (int c = 0; c < CHUNKS; c++) begin
                ip = (c * LANES + j < IN_PIXS) ? c * LANES + j : 0;
                if (c * LANES + j < IN_PIXS && k == K_W'(c)) begin
                    pix_w = PROD_W'($signed(vec[IN_BITW*ip +: IN_BITW]));
                    for (int o = 0; o < OUT_PIXS; o++) begin
                        if (op == OP_W'(o)) begin
                            flt_w = PROD_W'($signed(FLT[IN_BITW*(IN_PIXS*o+ip) +: IN_BITW]));
                        end
                    end
                end
            end
        end
        assign prod[j] = pix_w * flt_w;
    end

    always_comb begin
        partial = '0;
        for (int j = 0; j < LANES; j++) begin
            partial = partial + ACC_BITW'(prod[j]);
        end
        bias_w = '0;
        for (int o = 0; o < OUT_PIXS; o++) begin
            if (op == OP_W'(o)) bias_w = BIAS[OUT_BITW*o +: OUT_BITW];
        end
        base = (k == '0) ? ACC_BITW'(bias_w) : acc;
        sum  = base + partial;
    end

    forward_saturate #(
        .IN_W  (ACC_BITW),
        .OUT_W (OUT_BITW),
        .RELU  (RELU)
    ) u_sat (
        .din  (sum),
        .dout (sat)
    );

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            op      <= '0;
            k       <= '0;
            acc     <= '0;
            vec     <= '0;
            out_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        vec <= bus.in_pixels;
                        op  <= '0;
                        k   <= '0;
                    end
                end
                RUN: begin
                    acc <= sum;
                    if (last_chunk) begin
                        for (int o = 0; o < OUT_PIXS; o++) begin
                            if (op == OP_W'(o)) out_reg[OUT_BITW*o +: OUT_BITW] <= sat;
                        end
                        k  <= '0;
                        op <= last_op ? '0 : op + OP_W'(1);
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_forward_folded.sv
// Bench for forward_folded: seven differently parametrised instances driven through shared tasks.
module tb_forward_folded;
    import forward_folded_pkg::*;

    localparam int NDUT = 7;
    localparam int INP_ALL   [NDUT] = '{4, 4, 4, 5, 4, 4, 4};
    localparam int LANES_ALL [NDUT] = '{2, 2, 2, 2, 1, 2, 4};
    localparam int RELU_ALL  [NDUT] = '{0, 0, 1, 0, 0, 0, 1};
    localparam logic [79:0] FLT_ALL [NDUT] = '{
        {{8{8'h10}}, 16'h0},
        {{4{8'h7F}}, {4{8'h80}}, 16'h0},
        {{4{8'h7F}}, {4{8'h80}}, 16'h0},
        {10{8'h10}},
        {64'h1EF307C925FA11D8, 16'h0},
        {64'h807F01FF40C023DD, 16'h0},
        {64'hE20DF937DB06EF28, 16'h0}
    };
    localparam logic [23:0] BIAS_ALL [NDUT] = '{
        24'h000000, 24'h000000, 24'h000000, 24'h000080,
        24'h0F0E80, 24'h7FF800, 24'h123F00
    };

    logic clock;
    logic n_rst;
    logic [63:0] drv_pix   [NDUT];
    logic        drv_valid [NDUT];
    logic        drv_ready [NDUT];
    logic [63:0] obs_pix   [NDUT];
    logic        obs_in_ready  [NDUT];
    logic        obs_out_valid [NDUT];
    state_t      obs_state [NDUT];

    int total;
    int bad;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int INP = INP_ALL[g];
        forward_folded_if #(.IN_W(8 * INP), .OUT_W(24)) bus ();
        assign bus.in_pixels     = drv_pix[g][8*INP-1:0];
        assign bus.in_valid      = drv_valid[g];
        assign bus.out_ready     = drv_ready[g];
        assign obs_pix[g]        = 64'(bus.out_pixels);
        assign obs_in_ready[g]   = bus.in_ready;
        assign obs_out_valid[g]  = bus.out_valid;
        forward_folded #(
            .IN_PIXS   (INP),
            .OUT_PIXS  (2),
            .INT_BITW  (4),
            .FRAC_BITW (4),
            .LANES     (LANES_ALL[g]),
            .RELU      (RELU_ALL[g]),
            .FLT       (FLT_ALL[g][79 -: 16*INP]),
            .BIAS      (BIAS_ALL[g])
        ) u_dut (
            .clock     (clock),
            .n_rst     (n_rst),
            .bus       (bus.slave),
            .dbg_state (obs_state[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout, need completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [23:0] model(input int idx, input logic [63:0] pix);
        logic [23:0] res;
        logic signed [7:0]  p8, f8;
        logic signed [11:0] b12;
        int inp, s;
        inp = INP_ALL[idx];
        res = '0;
        for (int o = 0; o < 2; o++) begin
            b12 = BIAS_ALL[idx][23-12*o -: 12];
            s = int'(b12);
            for (int ip = 0; ip < inp; ip++) begin
                p8 = pix[8*(inp-1-ip) +: 8];
                f8 = FLT_ALL[idx][79-8*(inp*o+ip) -: 8];
                s = s + int'(p8) * int'(f8);
            end
            if (s > 2047) s = 2047;
            if (s < -2048) s = -2048;
            if (RELU_ALL[idx] != 0 && s < 0) s = 0;
            res[23-12*o -: 12] = s[11:0];
        end
        return res;
    endfunction

    function automatic int latency(input int idx);
        return 2 * ((INP_ALL[idx] + LANES_ALL[idx] - 1) / LANES_ALL[idx]);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input int idx, input logic [63:0] pix);
        int n;
        n = 0;
        drv_pix[idx]   = pix;
        drv_valid[idx] = 1'b1;
        while (!obs_in_ready[idx] && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        total++;
        if (!obs_in_ready[idx]) begin
            bad++;
            $display("FAIL send_ready dut%0d: in_ready=%0b, need 1 within 50 cycles", idx, obs_in_ready[idx]);
        end
        @(posedge clock); #1;
        drv_valid[idx] = 1'b0;
    endtask

    task automatic wait_out(input int idx, output int cyc);
        cyc = 0;
        while (!obs_out_valid[idx] && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
        end
    endtask

    task automatic release_out(input int idx);
        drv_ready[idx] = 1'b1;
        @(posedge clock); #1;
        drv_ready[idx] = 1'b0;
    endtask

    function automatic logic [63:0] fill(input int n, input logic [7:0] b);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(b);
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_rst = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < NDUT; i++) begin
            total++;
            if (obs_in_ready[i] !== 1'b1) begin
                bad++; $display("FAIL reset_in_ready dut%0d: got %0b need 1", i, obs_in_ready[i]);
            end
            total++;
            if (obs_out_valid[i] !== 1'b0) begin
                bad++; $display("FAIL reset_out_valid dut%0d: got %0b need 0", i, obs_out_valid[i]);
            end
            total++;
            if (obs_pix[i] !== 64'h0) begin
                bad++; $display("FAIL reset_out_pixels dut%0d: got %h need 0", i, obs_pix[i]);
            end
            total++;
            if (obs_state[i] !== IDLE) begin
                bad++; $display("FAIL reset_state dut%0d: got %0d need IDLE", i, obs_state[i]);
            end
        end
    endtask

    task automatic test_basic();
        int cyc;
        send(0, fill(4, 8'h10));
        total++;
        if (obs_in_ready[0] !== 1'b0) begin
            bad++; $display("FAIL basic_busy: in_ready=%0b need 0 during RUN", obs_in_ready[0]);
        end
        wait_out(0, cyc);
        total++;
        if (cyc !== 4) begin
            bad++; $display("FAIL basic_latency: got %0d cycles need 4", cyc);
        end
        total++;
        if (obs_pix[0][23:0] !== 24'h400400) begin
            bad++; $display("FAIL basic_result: got %h need 400400", obs_pix[0][23:0]);
        end
        release_out(0);
        total++;
        if (obs_in_ready[0] !== 1'b1 || obs_out_valid[0] !== 1'b0) begin
            bad++; $display("FAIL basic_release: in_ready=%0b out_valid=%0b need 1/0",
                            obs_in_ready[0], obs_out_valid[0]);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        logic [23:0] want [3];
        want[0] = 24'h0;
        want[1] = 24'h7FF800;
        want[2] = 24'h7FF000;
        for (int idx = 1; idx <= 2; idx++) begin
            send(idx, fill(4, 8'h7F));
            wait_out(idx, cyc);
            total++;
            if (obs_pix[idx][23:0] !== want[idx]) begin
                bad++; $display("FAIL saturate dut%0d: got %h need %h", idx, obs_pix[idx][23:0], want[idx]);
            end
            release_out(idx);
        end
    endtask

    task automatic test_uneven();
        int cyc;
        send(3, fill(5, 8'h10));
        wait_out(3, cyc);
        total++;
        if (cyc !== 6) begin
            bad++; $display("FAIL uneven_latency: got %0d cycles need 6", cyc);
        end
        total++;
        if (obs_pix[3][23:0] !== 24'h500580) begin
            bad++; $display("FAIL uneven_result: got %h need 500580", obs_pix[3][23:0]);
        end
        release_out(3);
    endtask

    task automatic test_backpressure();
        int cyc;
        send(0, fill(4, 8'h10));
        wait_out(0, cyc);
        drv_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drv_pix[0] = {$urandom(), $urandom()};
            @(posedge clock); #1;
            total++;
            if (obs_pix[0][23:0] !== 24'h400400 || obs_out_valid[0] !== 1'b1) begin
                bad++; $display("FAIL bp_hold cyc%0d: got %h valid=%0b need 400400 valid=1",
                                i, obs_pix[0][23:0], obs_out_valid[0]);
            end
            total++;
            if (obs_in_ready[0] !== 1'b0 || obs_state[0] !== DONE) begin
                bad++; $display("FAIL bp_no_accept cyc%0d: in_ready=%0b state=%0d need 0/DONE",
                                i, obs_in_ready[0], obs_state[0]);
            end
        end
        drv_valid[0] = 1'b0;
        release_out(0);
        total++;
        if (obs_in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL bp_release: in_ready=%0b need 1", obs_in_ready[0]);
        end
        @(posedge clock); #1;
        total++;
        if (obs_state[0] !== IDLE) begin
            bad++; $display("FAIL bp_idle: state=%0d need IDLE", obs_state[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [63:0] pix;
        send(0, fill(4, 8'h7F));
        repeat (2) @(posedge clock);
        #1;
        n_rst = 1'b0;
        #1;
        total++;
        if (obs_in_ready[0] !== 1'b1 || obs_out_valid[0] !== 1'b0) begin
            bad++; $display("FAIL rst_run_hs: in_ready=%0b out_valid=%0b need 1/0",
                            obs_in_ready[0], obs_out_valid[0]);
        end
        total++;
        if (obs_pix[0] !== 64'h0) begin
            bad++; $display("FAIL rst_run_pixels: got %h need 0", obs_pix[0]);
        end
        @(posedge clock); #3;
        n_rst = 1'b1;
        @(posedge clock); #1;
        pix = {32'h0, 8'h05, 8'hF0, 8'h21, 8'hFD};
        send(0, pix);
        wait_out(0, cyc);
        total++;
        if (cyc !== 4 || obs_pix[0][23:0] !== model(0, pix)) begin
            bad++; $display("FAIL rst_run_next: got %h after %0d cycles need %h after 4",
                            obs_pix[0][23:0], cyc, model(0, pix));
        end
        release_out(0);
    endtask

    task automatic test_sweep();
        int idx, cyc, tries;
        logic [63:0] pix;
        logic [23:0] exp_v;
        logic [7:0]  b;
        logic r;
        for (int i = 0; i < 200; i++) begin
            idx = 4 + (i % 3);
            pix = '0;
            for (int ip = 0; ip < 4; ip++) begin
                if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 255));
                else b = 8'($urandom_range(0, 31) - 16);
                pix = (pix << 8) | 64'(b);
            end
            exp_v = model(idx, pix);
            send(idx, pix);
            wait_out(idx, cyc);
            total++;
            if (cyc !== latency(idx)) begin
                bad++; $display("FAIL sweep_latency #%0d dut%0d: got %0d need %0d", i, idx, cyc, latency(idx));
            end
            total++;
            if (obs_pix[idx][23:0] !== exp_v) begin
                bad++; $display("FAIL sweep_result #%0d dut%0d pix=%h: got %h need %h",
                                i, idx, pix[31:0], obs_pix[idx][23:0], exp_v);
            end
            tries = 0;
            r = 1'b0;
            while (!r) begin
                r = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                drv_ready[idx] = r;
                @(posedge clock); #1;
                tries++;
                total++;
                if (r && obs_in_ready[idx] !== 1'b1) begin
                    bad++; $display("FAIL sweep_release #%0d: in_ready=%0b need 1", i, obs_in_ready[idx]);
                end else if (!r && (obs_out_valid[idx] !== 1'b1 || obs_pix[idx][23:0] !== exp_v)) begin
                    bad++; $display("FAIL sweep_hold #%0d: valid=%0b pix=%h need 1/%h",
                                    i, obs_out_valid[idx], obs_pix[idx][23:0], exp_v);
                end
            end
            drv_ready[idx] = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_rst = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            drv_pix[i]   = '0;
            drv_valid[i] = 1'b0;
            drv_ready[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_saturation();
        test_uneven();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
